// File: rtl/queue.sv
// queue: parameterised synchronous FIFO built on a circular buffer.
// Same push/pop command interface as the LIFO stack, but words come out
// first-in-first-out. Status flags are decoded from a registered occupancy
// counter, and single-cycle error pulses report refused commands.
module queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4   // power of two, at least 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Pointers wrap modulo DEPTH through natural overflow of PTR_W bits.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic             overflow_q,  overflow_d;
  logic             underflow_q, underflow_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Accepted-command qualifiers.
  logic do_push;
  logic do_pop;
  logic is_empty;
  logic is_full;

  // Flags are decoded from the registered count, so they carry no
  // combinational path from push, pop or din.
  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == DEPTH_C);
  end

  // Decide which commands are accepted this cycle. A pop is accepted
  // whenever the queue holds something. A push is accepted when there is
  // room, or when the queue is full but an accepted pop frees the head
  // slot in the same cycle. With the queue empty, push+pop stores the word
  // and refuses the pop: there is no write-through bypass.
  always_comb begin
    do_pop  = pop  && !is_empty;
    do_push = push && (!is_full || do_pop);
  end

  // Next-state logic for pointers, occupancy, read data and error pulses.
  // NOTE: every signal gets a default at the top of this block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see
    // the updated value; the registers below use non-blocking '<='.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = push && !do_push;
    underflow_d = pop  && !do_pop;

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (do_pop) begin
      // Reads the old head: a word written this cycle lands in mem_q only
      // after the edge, so it can never be returned by the same pop.
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and data-output registers with synchronous reset; reset wins
  // over any push or pop sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array write port.
  // NOTE: the array is deliberately not reset; occupancy is tracked by the
  // pointers and count, so stale contents are never observable, and leaving
  // it unreset lets it map onto plain register files or RAM.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout      = dout_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_queue.sv
// tb_queue: table-driven bench for the queue FIFO (WIDTH=4, DEPTH=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the following rising edge.
module tb_queue;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [2:0]       count;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_pass   = 0;

  queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .din       (din),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       push;
    logic       pop;
    logic [3:0] din;
    logic [3:0] e_dout;
    logic [2:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic pu, input logic po,
                              input logic [3:0] d, input logic [3:0] ed,
                              input logic [2:0] ec, input logic ee,
                              input logic ef, input logic eo, input logic eu);
    vec_t v;
    v.rst = r; v.push = pu; v.pop = po; v.din = d;
    v.e_dout = ed; v.e_count = ec; v.e_empty = ee; v.e_full = ef;
    v.e_ovf = eo; v.e_unf = eu;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and wait until outputs are stable.
  task automatic step(input logic r, input logic pu, input logic po,
                      input logic [3:0] d);
    @(negedge clk);
    rst = r; push = pu; pop = po; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] ed,
                           input logic [2:0] ec, input logic ee,
                           input logic ef, input logic eo, input logic eu);
    check({tag, ".dout"},      32'(dout),      32'(ed));
    check({tag, ".count"},     32'(count),     32'(ec));
    check({tag, ".empty"},     32'(empty),     32'(ee));
    check({tag, ".full"},      32'(full),      32'(ef));
    check({tag, ".overflow"},  32'(overflow),  32'(eo));
    check({tag, ".underflow"}, 32'(underflow), 32'(eu));
  endtask

  initial begin
    //   rst push pop din | dout cnt emp full ovf unf
    // Reset state.
    add(1, 0, 0,  0,    0, 0, 1, 0, 0, 0);
    // In-order drain.
    add(0, 1, 0,  3,    0, 1, 0, 0, 0, 0);
    add(0, 1, 0,  7,    0, 2, 0, 0, 0, 0);
    add(0, 1, 0, 12,    0, 3, 0, 0, 0, 0);
    add(0, 1, 0, 15,    0, 4, 0, 1, 0, 0);
    add(0, 0, 1,  0,    3, 3, 0, 0, 0, 0);
    add(0, 0, 1,  0,    7, 2, 0, 0, 0, 0);
    add(0, 0, 1,  0,   12, 1, 0, 0, 0, 0);
    add(0, 0, 1,  0,   15, 0, 1, 0, 0, 0);
    // Overflow: fill, push 9 refused, pulse lasts one cycle.
    add(0, 1, 0,  3,   15, 1, 0, 0, 0, 0);
    add(0, 1, 0,  7,   15, 2, 0, 0, 0, 0);
    add(0, 1, 0, 12,   15, 3, 0, 0, 0, 0);
    add(0, 1, 0, 15,   15, 4, 0, 1, 0, 0);
    add(0, 1, 0,  9,   15, 4, 0, 1, 1, 0);
    add(0, 0, 0,  0,   15, 4, 0, 1, 0, 0);
    add(0, 0, 1,  0,    3, 3, 0, 0, 0, 0);
    add(0, 0, 1,  0,    7, 2, 0, 0, 0, 0);
    add(0, 0, 1,  0,   12, 1, 0, 0, 0, 0);
    add(0, 0, 1,  0,   15, 0, 1, 0, 0, 0);
    // Underflow from reset, then push 5 / pop.
    add(1, 0, 0,  0,    0, 0, 1, 0, 0, 0);
    add(0, 0, 1,  0,    0, 0, 1, 0, 0, 1);
    add(0, 0, 0,  0,    0, 0, 1, 0, 0, 0);
    add(0, 1, 0,  5,    0, 1, 0, 0, 0, 0);
    add(0, 0, 1,  0,    5, 0, 1, 0, 0, 0);
    // Simultaneous push/pop at 2 entries.
    add(0, 1, 0,  1,    5, 1, 0, 0, 0, 0);
    add(0, 1, 0,  2,    5, 2, 0, 0, 0, 0);
    add(0, 1, 1,  8,    1, 2, 0, 0, 0, 0);
    add(0, 0, 1,  0,    2, 1, 0, 0, 0, 0);
    add(0, 0, 1,  0,    8, 0, 1, 0, 0, 0);
    // Simultaneous push/pop while empty: push kept, pop refused.
    add(0, 1, 1,  6,    8, 1, 0, 0, 0, 1);
    add(0, 0, 1,  0,    6, 0, 1, 0, 0, 0);
    // Simultaneous push/pop while full: both occur, no overflow.
    add(0, 1, 0,  1,    6, 1, 0, 0, 0, 0);
    add(0, 1, 0,  2,    6, 2, 0, 0, 0, 0);
    add(0, 1, 0,  3,    6, 3, 0, 0, 0, 0);
    add(0, 1, 0,  4,    6, 4, 0, 1, 0, 0);
    add(0, 1, 1,  5,    1, 4, 0, 1, 0, 0);
    add(0, 0, 1,  0,    2, 3, 0, 0, 0, 0);
    add(0, 0, 1,  0,    3, 2, 0, 0, 0, 0);
    add(0, 0, 1,  0,    4, 1, 0, 0, 0, 0);
    add(0, 0, 1,  0,    5, 0, 1, 0, 0, 0);
    // Repeated refused pops keep underflow high; dout holds.
    add(0, 0, 1,  0,    5, 0, 1, 0, 0, 1);
    add(0, 0, 1,  0,    5, 0, 1, 0, 0, 1);
    // Push coinciding with reset is ignored.
    add(1, 1, 0,  9,    0, 0, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].din);
      check_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_count,
                vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Wrap-around: pointers start at 0 after the last reset and wrap
    // twice over ten push/pop pairs.
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, 4'(k));
      check($sformatf("wrap%0d.push.count", k), 32'(count), 32'd1);
      check($sformatf("wrap%0d.push.flags", k),
            32'({empty, full, overflow, underflow}), 32'd0);
      step(0, 0, 1, 0);
      check($sformatf("wrap%0d.pop.dout", k), 32'(dout), 32'(k));
      check($sformatf("wrap%0d.pop.count", k), 32'(count), 32'd0);
      check($sformatf("wrap%0d.pop.flags", k),
            32'({empty, full, overflow, underflow}), 32'b1000);
    end

    // Reset mid-operation discards contents and zeroes dout (9 before).
    step(0, 1, 0, 4);
    step(0, 1, 0, 11);
    step(0, 1, 0, 13);
    check_all("midrst.pre", 9, 3, 0, 0, 0, 0);
    step(1, 1, 0, 2);
    check_all("midrst.rst", 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0);
    check_all("midrst.pop", 0, 0, 1, 0, 0, 1);

    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
